// File: rtl/axidpram_wr_ctrl.sv
// Upstream write controller for the dual-port AXI RAM write path (axidpram_wr).
// Latency: accept to wr_en is 2 cycles with adready high. Peak rate is 1 beat per 3 cycles.
// Backpressure: s_ready drops outside IDLE and while DEPTH beats are outstanding (full).
//
// Ports:
//   w_clk, reset              clock (rising edge) and asynchronous active-low reset
//   s_valid/s_ready/s_data/   byte stream source; s_last marks the final beat of a frame
//   s_last
//   axiw_advalid/axiw_adready address handshake toward the RAM
//   wr_addr, port_en_0/1      write address and RAM port select (never both set)
//   wr_en, axi_datain         one-cycle write strobe and its data
//   rd_release                read side consumed the buffer, clears the fill count
//   full, frame_done, wr_err  fill flag, end-of-frame pulse, address-timeout pulse
//
// Optional feature: define AXIW_TIMEOUT_EN to abandon a beat after TIMEOUT cycles
// without adready (wr_err pulses). Without it ADDR waits forever and wr_err is 0.
module axidpram_wr_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
`ifdef AXIW_TIMEOUT_EN
  ,parameter int TIMEOUT = 15
`endif
) (
  input  logic              w_clk,
  input  logic              reset,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              axiw_advalid,
  input  logic              axiw_adready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              port_en_0,
  output logic              port_en_1,
  output logic              wr_en,
  output logic [DATA_W-1:0] axi_datain,
  input  logic              rd_release,
  output logic              full,
  output logic              frame_done,
  output logic              wr_err
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ADDR, WRITE} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  wr_ptr;
  logic               port_sel;
  logic [CNT_W-1:0]   beat_cnt;
  logic [DATA_W-1:0]  data_q;
  logic               last_q;
  logic               frame_done_q;
  logic               wr_exit;
  logic               timeout_hit;

  assign full    = (beat_cnt == CNT_W'(DEPTH));
  // Gated by reset so every output reads 0 while reset is held.
  assign s_ready = reset && (state_q == IDLE) && !full;
  assign wr_exit = (state_q == WRITE);
  assign frame_done = frame_done_q;

`ifdef AXIW_TIMEOUT_EN
  logic [3:0] wait_cnt;

  // Counts consecutive ADDR cycles without adready; cleared whenever ADDR is left.
  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
    end else if (state_q == ADDR && !axiw_adready) begin
      wait_cnt <= wait_cnt + 4'd1;
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout_hit = (state_q == ADDR) && !axiw_adready && (wait_cnt == 4'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    axiw_advalid = 1'b0;
    wr_addr      = '0;
    port_en_0    = 1'b0;
    port_en_1    = 1'b0;
    wr_en        = 1'b0;
    axi_datain   = '0;
    wr_err       = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid && s_ready) state_d = ADDR;
      end
      ADDR: begin
        axiw_advalid = 1'b1;
        wr_addr      = wr_ptr;
        port_en_0    = !port_sel;
        port_en_1    = port_sel;
        axi_datain   = data_q;
        if (axiw_adready) begin
          state_d = WRITE;
        end else if (timeout_hit) begin
          // Beat is abandoned; pointer, port and fill count are left untouched.
          wr_err  = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        wr_en      = 1'b1;
        wr_addr    = wr_ptr;
        port_en_0  = !port_sel;
        port_en_1  = port_sel;
        axi_datain = data_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge w_clk or negedge reset) begin
    if (!reset) begin
      wr_ptr       <= '0;
      port_sel     <= 1'b0;
      beat_cnt     <= '0;
      data_q       <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      if (s_valid && s_ready) begin
        data_q <= s_data;
        last_q <= s_last;
      end
      frame_done_q <= wr_exit && last_q;
      if (wr_exit) begin
        if (last_q) begin
          // A new frame always starts at address 0 on port 0.
          wr_ptr   <= '0;
          port_sel <= 1'b0;
        end else begin
          wr_ptr   <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
          port_sel <= !port_sel;
        end
      end
      // A release coinciding with a write keeps that write counted.
      if (rd_release) begin
        beat_cnt <= wr_exit ? CNT_W'(1) : '0;
      end else if (wr_exit && !full) begin
        beat_cnt <= beat_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axidpram_wr_ctrl.sv
// Self-checking bench for axidpram_wr_ctrl: directed vector table, corner-case
// sequences (stall, full, reset in ADDR, optional timeout) and a random phase
// checked against a transaction-level reference model.
module tb_axidpram_wr_ctrl;
  localparam int DEPTH = 16;

  logic       w_clk = 1'b0;
  logic       reset = 1'b0;
  logic       s_valid = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic       s_last = 1'b0;
  logic       axiw_adready = 1'b1;
  logic       rd_release = 1'b0;
  logic       s_ready, axiw_advalid, port_en_0, port_en_1, wr_en, full, frame_done, wr_err;
  logic [3:0] wr_addr;
  logic [7:0] axi_datain;

  axidpram_wr_ctrl dut (
    .w_clk(w_clk), .reset(reset), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_last(s_last), .axiw_advalid(axiw_advalid), .axiw_adready(axiw_adready),
    .wr_addr(wr_addr), .port_en_0(port_en_0), .port_en_1(port_en_1), .wr_en(wr_en),
    .axi_datain(axi_datain), .rd_release(rd_release), .full(full),
    .frame_done(frame_done), .wr_err(wr_err)
  );

  always #5 w_clk = ~w_clk;

  int n_vec = 0;
  int n_miss = 0;

  // Reference model: next address, next port, beats outstanding.
  int m_ptr = 0;
  int m_port = 0;
  int m_cnt = 0;

  typedef struct {
    logic [7:0] d;
    logic       l;
    int         stall;
    logic [3:0] e_addr;
    logic       e_port;
  } vec_t;
  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_advance(input logic l);
    if (l) begin
      m_ptr = 0;
      m_port = 0;
    end else begin
      m_ptr = (m_ptr + 1) % DEPTH;
      m_port = 1 - m_port;
    end
    if (m_cnt < DEPTH) m_cnt++;
  endfunction

  // Called at a negedge. Offers one beat, holds adready low for 'stall' ADDR
  // cycles, then checks the write beat and the frame_done cycle that follows.
  task automatic send_beat(input logic [7:0] d, input logic l, input int stall,
                           input logic [3:0] ea, input logic ep);
    int  w;
    int  lat;
    bit  done;
    w = 0;
    while (s_ready !== 1'b1 && w < 50) begin
      @(negedge w_clk);
      w++;
    end
    check("s_ready_before_beat", s_ready, 1);
    s_valid = 1'b1;
    s_data = d;
    s_last = l;
    axiw_adready = (stall == 0);
    @(negedge w_clk);
    s_valid = 1'b0;
    s_data = 8'($urandom);
    s_last = 1'($urandom);
    lat = 1;
    done = 0;
    while (!done && lat < 40) begin
      if (wr_en === 1'b1) begin
        check("wr_latency", lat, stall + 2);
        check("wr_addr", wr_addr, ea);
        check("port_en_0", port_en_0, !ep);
        check("port_en_1", port_en_1, ep);
        check("axi_datain", axi_datain, d);
        check("wr_err_idle", wr_err, 0);
        done = 1;
      end else begin
        check("advalid_hold", axiw_advalid, 1);
        check("addr_hold", wr_addr, ea);
        check("port_hold", {port_en_1, port_en_0}, ep ? 2 : 1);
        if (lat == stall + 1) axiw_adready = 1'b1;
        @(negedge w_clk);
        lat++;
      end
    end
    if (!done) check("wr_en_seen", 0, 1);
    @(negedge w_clk);
    check("frame_done", frame_done, l);
    check("wr_en_one_cycle", wr_en, 0);
  endtask

  task automatic model_beat(input logic [7:0] d, input logic l, input int stall);
    send_beat(d, l, stall, 4'(m_ptr), 1'(m_port));
    model_advance(l);
    check("full", full, m_cnt == DEPTH);
    check("s_ready_after", s_ready, m_cnt != DEPTH);
  endtask

  task automatic release_pulse();
    rd_release = 1'b1;
    @(negedge w_clk);
    rd_release = 1'b0;
    m_cnt = 0;
    check("full_after_release", full, 0);
    check("s_ready_after_release", s_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    tbl[0] = '{8'hA5, 1'b0, 0, 4'd0, 1'b0};
    tbl[1] = '{8'h3C, 1'b0, 0, 4'd1, 1'b1};
    tbl[2] = '{8'h11, 1'b1, 6, 4'd2, 1'b0};
    tbl[3] = '{8'h22, 1'b0, 0, 4'd0, 1'b0};
    tbl[4] = '{8'h33, 1'b0, 2, 4'd1, 1'b1};

    // Reset state
    repeat (3) @(negedge w_clk);
    check("s_ready_in_reset", s_ready, 0);
    reset = 1'b1;
    @(negedge w_clk);
    check("rst_s_ready", s_ready, 1);
    check("rst_advalid", axiw_advalid, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_port_en", {port_en_1, port_en_0}, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_full", full, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_wr_err", wr_err, 0);

    // Directed table: back-to-back, stalled address phase, frame end
    for (int i = 0; i < 5; i++) begin
      send_beat(tbl[i].d, tbl[i].l, tbl[i].stall, tbl[i].e_addr, tbl[i].e_port);
      model_advance(tbl[i].l);
    end
    model_beat(8'h44, 1'b0, 0);

    // Reset asserted during ADDR drops the beat
    s_valid = 1'b1;
    s_data = 8'h99;
    axiw_adready = 1'b0;
    @(negedge w_clk);
    s_valid = 1'b0;
    check("addr_phase_before_reset", axiw_advalid, 1);
    reset = 1'b0;
    #1;
    check("rstaddr_advalid", axiw_advalid, 0);
    check("rstaddr_port_en", {port_en_1, port_en_0}, 0);
    check("rstaddr_wr_en", wr_en, 0);
    check("rstaddr_s_ready", s_ready, 0);
    check("rstaddr_wr_addr", wr_addr, 0);
    repeat (2) @(negedge w_clk);
    reset = 1'b1;
    axiw_adready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge w_clk);
      if (wr_en === 1'b1) seen++;
    end
    check("dropped_beat_no_wr_en", seen, 0);
    m_ptr = 0;
    m_port = 0;
    m_cnt = 0;
    model_beat(8'h5A, 1'b0, 0);

    // Fill to DEPTH, hold valid while full, then release
    release_pulse();
    for (int i = 0; i < DEPTH; i++) model_beat(8'($urandom), 1'b0, 0);
    check("full_after_depth", full, 1);
    s_valid = 1'b1;
    s_data = 8'hEE;
    seen = 0;
    repeat (5) begin
      @(negedge w_clk);
      if (wr_en === 1'b1 || axiw_advalid === 1'b1) seen++;
    end
    s_valid = 1'b0;
    check("no_write_while_full", seen, 0);
    release_pulse();
    model_beat(8'h77, 1'b0, 0);

`ifdef AXIW_TIMEOUT_EN
    // Address timeout: beat abandoned, model state unchanged
    s_valid = 1'b1;
    s_data = 8'hBB;
    axiw_adready = 1'b0;
    @(negedge w_clk);
    s_valid = 1'b0;
    lat = 1;
    seen = 0;
    while (wr_err !== 1'b1 && lat < 40) begin
      if (wr_en === 1'b1) seen++;
      @(negedge w_clk);
      lat++;
    end
    check("timeout_cycles", lat, 15);
    check("timeout_no_wr_en", seen, 0);
    @(negedge w_clk);
    check("timeout_wr_err_pulse", wr_err, 0);
    axiw_adready = 1'b1;
    model_beat(8'hCC, 1'b0, 0);
`endif

    // Randomised traffic against the model
    for (int i = 0; i < 150; i++) begin
      if (m_cnt == DEPTH) begin
        check("s_ready_when_full", s_ready, 0);
        release_pulse();
      end else if ($urandom_range(0, 5) == 0) begin
        release_pulse();
      end
      model_beat(8'($urandom), 1'($urandom_range(0, 7) == 0), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  // Structural invariant checked on every cycle
  always @(negedge w_clk) begin
    if (port_en_0 === 1'b1 && port_en_1 === 1'b1) begin
      n_vec++;
      n_miss++;
      $display("FAIL port_en_exclusive: got 3 expected at most one set");
    end
  end

endmodule
